multi_arr_seq_ctrl: RTL
=======================

// Module: multi_arr_seq_ctrl
// PURPOSE
//  Sequencer for the 4x4 outer-product multiplier array (top_multi_arr).
//  Accepts a stream of LEN (weight-vector, input-vector) pairs over a valid/ready
//  handshake and drives them into the array through registers. It accumulates the
//  16 array products into 16 accumulators, then holds the tile result until consumed.
//  Sits between the operand fetch logic and the result writeback.
// PARAMETERS
//  DW     16  operand width of each wts/ips lane
//  PW     32  product width of each array output (arr_ops lane)
//  ACC_W  40  accumulator width; >= PW+8 so that 255 steps never overflow
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  start      in   1          begin a tile; sampled only in IDLE
//  len        in   8          number of vector pairs in the tile; sampled with start
//  busy       out  1          high in any state other than IDLE
//  in_valid   in   1          operand pair valid
//  in_ready   out  1          ready for an operand pair; high only in RUN
//  in_wts     in   [3:0][DW]  weight vector
//  in_ips     in   [3:0][DW]  input vector
//  arr_wts    out  [3:0][DW]  registered drive to array .wts
//  arr_ips    out  [3:0][DW]  registered drive to array .ips
//  arr_ops    in   [15:0][PW] array products; arr_ops[4*i+j] = wts[i]*ips[j], unsigned
//  out_valid  out  1          tile result valid; high only in DONE
//  out_ready  in   1          consumer accepts the result
//  out_acc    out  [15:0][ACC_W] accumulated products, unsigned
// BEHAVIOUR
//  Reset: FSM=IDLE, cnt=0, prod_vld=0, and arr_wts, arr_ips, out_acc all 0.
//   busy, in_ready and out_valid are 0. Reset takes effect immediately, from any state.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE:  start=1 and len!=0 -> latch len; clear all acc to 0; cnt=0; next state RUN.
//         start=1 with len==0 is ignored: no state change and no acc clear.
//         in_valid is ignored.
//  RUN:   in_ready=1. An operand pair is accepted when in_valid & in_ready are both high.
//         On accept: arr_wts<=in_wts, arr_ips<=in_ips, prod_vld<=1, cnt<=cnt+1.
//         Otherwise arr_* hold their values and prod_vld<=0.
//         On every edge with prod_vld=1: acc[k] <= acc[k] + zero-extended arr_ops[k].
//         The array is combinational, so the product lands 2 edges after accept.
//         The accept that makes cnt==len moves the FSM to DRAIN on the same edge.
//         in_valid bubbles are allowed and insert no extra products.
//  DRAIN: in_ready=0. Exactly one cycle long; it accumulates the last product.
//         Next state is DONE.
//  DONE:  out_valid=1. out_acc is stable until out_ready=1.
//         out_valid & out_ready -> IDLE. out_acc holds its value until the next start.
//  start while busy is ignored. len is not re-sampled mid-tile.
//  Arithmetic: unsigned throughout, with wrap modulo 2^ACC_W.
//   Worst case is 255*(2^PW-1) < 2^40, so no overflow occurs at the default widths.
//  Throughput: 1 pair/cycle in RUN. Tile latency is len + 3 cycles, from start to
//   out_valid, when in_valid is held high.
// TESTING
//  T1 len=1; wts={0x34,0x24,0x35,0x36}, ips={1,4,3,5}
//     -> out_acc[0]=52, [1]=208, [5]=144, [15]=270, with out_valid 4 cycles after start.
//  T2 len=3; same vector every step, with 1-cycle in_valid bubbles
//     -> out_acc[15]=810 and out_acc[0]=156; exactly 3 handshakes occur.
//  T3 Hold out_ready=0 for 5 cycles in DONE and pulse start
//     -> out_acc stable, in_ready=0, start ignored. out_ready=1 -> IDLE next cycle.
//  T4 len=255; all lanes 0xFFFF
//     -> every out_acc[k] = 0xFEFE0200FF (no wrap).
//  T5 Drop rst_n mid-RUN (after 2 accepts)
//     -> outputs 0 and busy=0 immediately, with no clock needed.
//     A new T1 tile afterwards gives the T1 values.
//  T6 start with len=0 in IDLE
//     -> busy stays 0, in_ready stays 0, and the prior out_acc is unchanged.

Source files
------------

// File: rtl/multi_arr_seq_ctrl.sv
// Sequencer for the 4x4 outer-product array: registers LEN operand pairs into the array, accumulates 16 products.
// Tile latency len+3 cycles from start to out_valid; in_ready only in RUN, result held in DONE until out_ready.
module multi_arr_seq_ctrl #(
  parameter int DW    = 16,
  parameter int PW    = 32,
  parameter int ACC_W = 40
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  len,
  output logic                        busy,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [3:0][DW-1:0]          in_wts,
  input  logic [3:0][DW-1:0]          in_ips,
  output logic [3:0][DW-1:0]          arr_wts,
  output logic [3:0][DW-1:0]          arr_ips,
  input  logic [15:0][PW-1:0]         arr_ops,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [15:0][ACC_W-1:0]      out_acc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [7:0]               len_q;
  logic [7:0]               cnt;
  logic [7:0]               cnt_inc;
  logic                     prod_vld;
  logic                     accept;
  logic                     tile_go;
  logic [15:0][ACC_W-1:0]   acc;

  assign cnt_inc = cnt + 8'd1;
  assign accept  = in_valid & in_ready;
  assign tile_go = (state == IDLE) && start && (len != 8'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (tile_go) state_nxt = RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (accept && (cnt_inc == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand registers feed the combinational array; prod_vld marks a product one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= 8'd0;
      cnt      <= 8'd0;
      prod_vld <= 1'b0;
      arr_wts  <= '0;
      arr_ips  <= '0;
    end else begin
      prod_vld <= accept;
      if (tile_go) begin
        len_q <= len;
        cnt   <= 8'd0;
      end else if (accept) begin
        cnt <= cnt_inc;
      end
      if (accept) begin
        arr_wts <= in_wts;
        arr_ips <= in_ips;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (tile_go) begin
      acc <= '0;
    end else if (prod_vld) begin
      for (int k = 0; k < 16; k++) begin
        acc[k] <= acc[k] + {{(ACC_W-PW){1'b0}}, arr_ops[k]};
      end
    end
  end

  assign out_acc = acc;

endmodule
